// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions used by both the display driver and the scan decoder,
// so the encode and decode tables always come from one source.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low patterns, segment a in bit 0 through segment g in bit 6, indexed by nibble
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    function automatic seg_t seg_encode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       invalid_o
);

    // Anything that is neither blank nor in the table reports as blank and invalid
    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = 1'b1;
        invalid_o = 1'b1;
        if (seg_i == SEG_BLANK) begin
            invalid_o = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg_i == SEG_TABLE[i]) begin
                    nibble_o  = 4'(i);
                    blank_o   = 1'b0;
                    invalid_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Passive monitor of a multiplexed 4-digit 7-segment bus; rebuilds the displayed
// nibbles and publishes them as one coherent frame with valid/error flags.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] digits_o,
    output logic [3:0]  blank_o,
    output logic        valid_o,
    output logic        frame_o,
    output logic        err_o
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][3:0] an_sync_q, an_sync_d;
    logic [SYNC_STAGES-1:0][6:0] seg_sync_q, seg_sync_d;
    logic [3:0]        an_prev_q, an_prev_d;
    seg_t              seg_prev_q, seg_prev_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [0:0]        state_q, state_d;
    logic [3:0]        seen_q, seen_d;
    logic [15:0]       shadow_digits_q, shadow_digits_d;
    logic [3:0]        shadow_blank_q, shadow_blank_d;
    logic [15:0]       digits_q, digits_d;
    logic [3:0]        blank_q, blank_d;
    logic              valid_q, valid_d;
    logic              frame_q, frame_d;
    logic              err_q, err_d;

    logic [3:0]  an_s;
    seg_t        seg_s;
    logic        sample_changed;
    logic        accept;
    logic        complete;
    logic        timeout;
    logic [1:0]  digit_idx;
    logic [3:0]  dec_nibble;
    logic        dec_blank;
    logic        dec_invalid;

    sevenseg_pattern_decode u_decode (
        .seg_i     (seg_s),
        .nibble_o  (dec_nibble),
        .blank_o   (dec_blank),
        .invalid_o (dec_invalid)
    );

    assign an_s  = an_sync_q[SYNC_STAGES-1];
    assign seg_s = seg_sync_q[SYNC_STAGES-1];

    always_comb begin
        an_sync_d      = {an_sync_q[SYNC_STAGES-2:0], an_i};
        seg_sync_d     = {seg_sync_q[SYNC_STAGES-2:0], seg_i};
        an_prev_d      = an_s;
        seg_prev_d     = seg_s;
        sample_changed = ({an_s, seg_s} != {an_prev_q, seg_prev_q});

        digit_idx = 2'd0;
        case (an_s)
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase

        if (sample_changed)
            stab_cnt_d = '0;
        else if (stab_cnt_q == STAB_MAX)
            stab_cnt_d = stab_cnt_q;
        else
            stab_cnt_d = stab_cnt_q + 1'b1;

        // The sample must still match this cycle so the decoded pattern is the stable one
        accept   = (state_q == S_WAIT) && (stab_cnt_q == STAB_MAX) &&
                   !sample_changed && $onehot(~an_s);
        complete = (seen_q == 4'hF);
        timeout  = (to_cnt_q == TO_LAST) && !accept;

        state_d = state_q;
        if (state_q == S_WAIT && accept)
            state_d = S_HOLD;
        else if (state_q == S_HOLD && sample_changed)
            state_d = S_WAIT;

        shadow_digits_d = shadow_digits_q;
        shadow_blank_d  = shadow_blank_q;
        err_d           = 1'b0;
        if (accept) begin
            shadow_digits_d[{digit_idx, 2'b00} +: 4] = dec_nibble;
            shadow_blank_d[digit_idx]                = dec_blank;
            err_d                                    = dec_invalid;
        end

        seen_d = seen_q;
        if (complete || timeout)
            seen_d = 4'h0;
        if (accept)
            seen_d = seen_d | (4'b0001 << digit_idx);

        to_cnt_d = (accept || timeout) ? '0 : to_cnt_q + 1'b1;

        // Completion overrides a coincident timeout
        valid_d  = valid_q;
        if (timeout)
            valid_d = 1'b0;
        if (complete)
            valid_d = 1'b1;
        frame_d  = complete;
        digits_d = complete ? shadow_digits_q : digits_q;
        blank_d  = complete ? shadow_blank_q : blank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_sync_q       <= '1;
            seg_sync_q      <= '1;
            an_prev_q       <= '1;
            seg_prev_q      <= '1;
            stab_cnt_q      <= '0;
            to_cnt_q        <= '0;
            state_q         <= S_WAIT;
            seen_q          <= 4'h0;
            shadow_digits_q <= 16'h0;
            shadow_blank_q  <= 4'hF;
            digits_q        <= 16'h0;
            blank_q         <= 4'hF;
            valid_q         <= 1'b0;
            frame_q         <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            an_sync_q       <= an_sync_d;
            seg_sync_q      <= seg_sync_d;
            an_prev_q       <= an_prev_d;
            seg_prev_q      <= seg_prev_d;
            stab_cnt_q      <= stab_cnt_d;
            to_cnt_q        <= to_cnt_d;
            state_q         <= state_d;
            seen_q          <= seen_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_blank_q  <= shadow_blank_d;
            digits_q        <= digits_d;
            blank_q         <= blank_d;
            valid_q         <= valid_d;
            frame_q         <= frame_d;
            err_q           <= err_d;
        end
    end

    assign digits_o = digits_q;
    assign blank_o  = blank_q;
    assign valid_o  = valid_q;
    assign frame_o  = frame_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: directed bus sequences push expected
// frames, a monitor pops and compares them whenever frame_o pulses.
module tb_sevenseg_scan_decoder;

    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic [15:0] digits_o;
    logic [3:0]  blank_o;
    logic        valid_o;
    logic        frame_o;
    logic        err_o;

    frame_t exp_q[$];
    int     vec_cnt        = 0;
    int     miss_cnt       = 0;
    int     frame_cnt      = 0;
    int     err_cnt        = 0;
    int     cyc            = 0;
    int     last_frame_cyc = 0;

    sevenseg_scan_decoder #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .an_i     (an_i),
        .seg_i    (seg_i),
        .digits_o (digits_o),
        .blank_o  (blank_o),
        .valid_o  (valid_o),
        .frame_o  (frame_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one bus state, called at a falling edge, and holds it for the given cycles
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        an_i  = an;
        seg_i = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic showFrame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        applyStimulus(4'b1110, s0, 40);
        applyStimulus(4'b1101, s1, 40);
        applyStimulus(4'b1011, s2, 40);
        applyStimulus(4'b0111, s3, 40);
    endtask

    initial begin : monitor
        frame_t exp_f;
        forever begin
            @(negedge clk);
            if (err_o)
                err_cnt++;
            if (frame_o) begin
                frame_cnt++;
                last_frame_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_f = exp_q.pop_front();
                    checkOutput("frame_digits", {16'h0, digits_o}, {16'h0, exp_f.digits});
                    checkOutput("frame_blank", {28'h0, blank_o}, {28'h0, exp_f.blank});
                    checkOutput("frame_valid", {31'h0, valid_o}, 32'd1);
                end
            end
        end
    end

    initial begin : stimulus
        int frames_before;
        int fall_cyc;
        rst   = 1'b1;
        an_i  = 4'hF;
        seg_i = 7'h7F;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_digits", {16'h0, digits_o}, 32'h0);
        checkOutput("reset_blank", {28'h0, blank_o}, 32'hF);
        checkOutput("reset_valid", {31'h0, valid_o}, 32'd0);
        checkOutput("reset_frame", {31'h0, frame_o}, 32'd0);
        checkOutput("reset_err", {31'h0, err_o}, 32'd0);

        // Single digit: one capture, no frame yet
        applyStimulus(4'b1110, 7'h24, 30);
        applyStimulus(4'hF, 7'h7F, 10);
        checkOutput("single_digit_no_frame", frame_cnt, 0);
        checkOutput("single_digit_no_err", err_cnt, 0);
        checkOutput("single_digit_valid", {31'h0, valid_o}, 32'd0);

        // Full frame 3,B,D,F
        exp_q.push_back('{digits: 16'hFDB3, blank: 4'h0});
        showFrame(7'h30, 7'h03, 7'h21, 7'h0E);
        checkOutput("full_frame_count", frame_cnt, 1);
        checkOutput("full_frame_valid", {31'h0, valid_o}, 32'd1);

        // Reset after two captures of C,D
        applyStimulus(4'b1110, 7'h46, 40);
        applyStimulus(4'b1101, 7'h21, 40);
        rst  = 1'b1;
        an_i = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_digits", {16'h0, digits_o}, 32'h0);
        checkOutput("midreset_blank", {28'h0, blank_o}, 32'hF);
        checkOutput("midreset_valid", {31'h0, valid_o}, 32'd0);
        frames_before = frame_cnt;
        applyStimulus(4'b1011, 7'h06, 40);
        applyStimulus(4'b0111, 7'h19, 40);
        checkOutput("midreset_no_early_frame", frame_cnt, frames_before);
        exp_q.push_back('{digits: 16'h4E10, blank: 4'h0});
        applyStimulus(4'b1110, 7'h40, 40);
        applyStimulus(4'b1101, 7'h79, 40);
        checkOutput("midreset_frame_count", frame_cnt, frames_before + 1);

        // Glitching segments never stay stable long enough to be captured
        frames_before = frame_cnt;
        for (int i = 0; i < 12; i++)
            applyStimulus(4'b1110, (i % 2 == 0) ? 7'h40 : 7'h79, 5);
        applyStimulus(4'b1101, 7'h79, 5);
        applyStimulus(4'b1011, 7'h24, 5);
        applyStimulus(4'b0111, 7'h30, 5);
        checkOutput("glitch_no_frame", frame_cnt, frames_before);
        exp_q.push_back('{digits: 16'h8765, blank: 4'h0});
        showFrame(7'h12, 7'h02, 7'h78, 7'h00);
        checkOutput("glitch_clean_frame", frame_cnt, frames_before + 1);

        // Blank digit 2 and undecodable digit 3
        exp_q.push_back('{digits: 16'h00A9, blank: 4'b1100});
        showFrame(7'h10, 7'h08, 7'h7F, 7'h55);
        checkOutput("invalid_err_count", err_cnt, 1);

        // Timeout: valid falls 64 cycles after the last acceptance, which is 63 after frame_o
        applyStimulus(4'hF, 7'h7F, 1);
        for (int i = 0; i < 200 && valid_o; i++)
            @(negedge clk);
        fall_cyc = cyc;
        checkOutput("timeout_valid_low", {31'h0, valid_o}, 32'd0);
        checkOutput("timeout_delay", fall_cyc - last_frame_cyc, TIMEOUT - 1);
        checkOutput("timeout_digits_held", {16'h0, digits_o}, 32'h00A9);
        checkOutput("timeout_blank_held", {28'h0, blank_o}, 32'hC);

        applyStimulus(4'hF, 7'h7F, 10);
        checkOutput("total_frames", frame_cnt, 4);
        checkOutput("total_err", err_cnt, 1);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
